// File: rtl/ibex_fetch_resp_pkg.sv
// Shared types and constants for the instruction fetch responder.
// Used by ibex_fetch_responder and ibex_fetch_resp_queue.
package ibex_fetch_resp_pkg;

  localparam logic [15:0] LfsrSeed   = 16'hACE1;
  localparam int unsigned CountdownW = 2;

  typedef struct packed {
    logic [31:0]           rdata;
    logic                  err;
    logic [CountdownW-1:0] countdown;
  } resp_entry_t;

  // Fibonacci LFSR, taps 16,14,13,11; the new bit enters at bit 0
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/ibex_fetch_resp_queue.sv
// In-order response queue: all entries count down together and the head
// is presented for exactly one cycle once its countdown reaches zero.
module ibex_fetch_resp_queue
  import ibex_fetch_resp_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push_i,
  input  resp_entry_t push_entry_i,
  output logic        pop_o,
  output logic [31:0] head_rdata_o,
  output logic        head_err_o,
  output logic        empty_o,
  output logic        full_o
);

  localparam int unsigned CntW = $clog2(Depth + 1);

  resp_entry_t         q     [Depth];
  resp_entry_t         dec   [Depth];
  resp_entry_t         q_nxt [Depth];
  logic [CntW-1:0]     count_q;
  logic [CntW-1:0]     count_nxt;
  logic [CntW-1:0]     wr_idx;

  assign empty_o      = (count_q == '0);
  assign full_o       = (count_q == CntW'(Depth));
  assign pop_o        = ~empty_o && (q[0].countdown == '0);
  assign head_rdata_o = q[0].rdata;
  assign head_err_o   = q[0].err;

  always_comb begin
    for (int i = 0; i < Depth; i++) begin
      dec[i] = q[i];
      if (q[i].countdown != '0) dec[i].countdown = q[i].countdown - CountdownW'(1);
    end
    q_nxt = dec;
    if (pop_o) begin
      for (int i = 0; i < Depth - 1; i++) q_nxt[i] = dec[i + 1];
      q_nxt[Depth-1] = '0;
    end
    // a same-cycle pop frees the slot just below the tail
    wr_idx = pop_o ? (count_q - CntW'(1)) : count_q;
    for (int i = 0; i < Depth; i++) begin
      if (push_i && (wr_idx == CntW'(i))) q_nxt[i] = push_entry_i;
    end
    count_nxt = count_q + CntW'(push_i) - CntW'(pop_o);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
      for (int i = 0; i < Depth; i++) q[i] <= '0;
    end else begin
      count_q <= count_nxt;
      for (int i = 0; i < Depth; i++) q[i] <= q_nxt[i];
    end
  end

endmodule

// File: rtl/ibex_fetch_responder.sv
// Instruction fetch responder with an internal backdoor-loaded store.
// Define IBEX_FETCH_RESP_STALL_EN to add LFSR-driven pseudo-random grant stalls.
module ibex_fetch_responder
  import ibex_fetch_resp_pkg::*;
#(
  parameter int unsigned MemWords       = 256,
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned RespLatency    = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        mem_we_i,
  input  logic [31:0] mem_waddr_i,
  input  logic [31:0] mem_wdata_i,
  output logic        busy_o
);

  localparam int unsigned AddrW     = (MemWords > 1) ? $clog2(MemWords) : 1;
  localparam logic [31:0] MemWordsW = 32'(MemWords);

  logic [31:0] mem [MemWords];
  logic        stall;
  logic        addr_err;
  logic        q_full;
  logic        q_empty;
  logic        q_pop;
  logic        head_err;
  logic [31:0] head_rdata;
  resp_entry_t push_entry;

`ifdef IBEX_FETCH_RESP_STALL_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) lfsr_q <= LfsrSeed;
    else       lfsr_q <= lfsr_step(lfsr_q);
  end

  assign stall = lfsr_q[0];
`else
  assign stall = 1'b0;
`endif

  assign addr_err = (instr_addr_i[1:0] != 2'b00) ||
                    ({2'b00, instr_addr_i[31:2]} >= MemWordsW);

  // full comes from the registered count, so a same-cycle pop never frees a slot
  assign instr_gnt_o = instr_req_i & ~q_full & ~stall & ~rst_i;

  always_comb begin
    push_entry.rdata     = addr_err ? 32'h0 : mem[instr_addr_i[AddrW+1:2]];
    push_entry.err       = addr_err;
    push_entry.countdown = CountdownW'(RespLatency - 1);
  end

  // store is read at grant time above, so a colliding write lands after the read
  always_ff @(posedge clk_i) begin
    if (mem_we_i && (mem_waddr_i < MemWordsW)) mem[mem_waddr_i[AddrW-1:0]] <= mem_wdata_i;
  end

  ibex_fetch_resp_queue #(
    .Depth (MaxOutstanding)
  ) u_queue (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .push_i       (instr_gnt_o),
    .push_entry_i (push_entry),
    .pop_o        (q_pop),
    .head_rdata_o (head_rdata),
    .head_err_o   (head_err),
    .empty_o      (q_empty),
    .full_o       (q_full)
  );

  assign instr_rvalid_o = q_pop & ~rst_i;
  assign instr_rdata_o  = instr_rvalid_o ? head_rdata : 32'h0;
  assign instr_err_o    = instr_rvalid_o & head_err;
  assign busy_o         = ~q_empty & ~rst_i;

endmodule

// File: tb/tb_ibex_fetch_responder.sv
// Bench for ibex_fetch_responder: two instances (RespLatency 1 and 3) share stimulus
// and are checked every cycle against a due-time queue model.
module tb_ibex_fetch_responder;

  localparam int N      = 2;
  localparam int MaxOut = 2;
  localparam int MemW   = 256;
  localparam int LogN   = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              req;
  logic              we;
  logic [31:0]       addr;
  logic [31:0]       waddr;
  logic [31:0]       wdata;
  logic [N-1:0]      gnt;
  logic [N-1:0]      rvalid;
  logic [N-1:0]      err;
  logic [N-1:0]      busy;
  logic [N-1:0][31:0] rdata;

  always #5 clk = ~clk;

  ibex_fetch_responder #(.MemWords(MemW), .MaxOutstanding(MaxOut), .RespLatency(1)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .instr_req_i(req), .instr_addr_i(addr),
    .instr_gnt_o(gnt[0]), .instr_rvalid_o(rvalid[0]), .instr_rdata_o(rdata[0]),
    .instr_err_o(err[0]), .mem_we_i(we), .mem_waddr_i(waddr), .mem_wdata_i(wdata),
    .busy_o(busy[0]));

  ibex_fetch_responder #(.MemWords(MemW), .MaxOutstanding(MaxOut), .RespLatency(3)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .instr_req_i(req), .instr_addr_i(addr),
    .instr_gnt_o(gnt[1]), .instr_rvalid_o(rvalid[1]), .instr_rdata_o(rdata[1]),
    .instr_err_o(err[1]), .mem_we_i(we), .mem_waddr_i(waddr), .mem_wdata_i(wdata),
    .busy_o(busy[1]));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int lat(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // model: each grant becomes a response due at max(grant+latency, previous due+1)
  logic [31:0] mem_m   [MemW];
  logic [31:0] q_rdata [N][16];
  logic        q_err   [N][16];
  int          q_due   [N][16];
  int          q_hd    [N];
  int          q_tl    [N];
  int          last_due[N];
  logic [15:0] lfsr_m = 16'hACE1;
  int          cyc = 0;

  int          g_n  [N];
  int          r_n  [N];
  int          g_cyc[N][LogN];
  int          r_cyc[N][LogN];
  logic [31:0] r_dat[N][LogN];
  logic        r_er [N][LogN];

  int          occ;
  int          due;
  logic        e_rv;
  logic        e_g;
  logic        e_err;
  logic        stall_m;

  initial begin
    for (int i = 0; i < N; i++) begin
      q_hd[i] = 0; q_tl[i] = 0; last_due[i] = -100; g_n[i] = 0; r_n[i] = 0;
    end
  end

  always @(negedge clk) begin
    stall_m = 1'b0;
`ifdef IBEX_FETCH_RESP_STALL_EN
    stall_m = lfsr_m[0];
`endif
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        q_hd[i] = q_tl[i];
        last_due[i] = -100;
      end
      occ  = q_tl[i] - q_hd[i];
      e_rv = (occ > 0) && (q_due[i][q_hd[i] % 16] == cyc);
      e_g  = !rst && req && (occ < MaxOut) && !stall_m;
      check($sformatf("gnt%0d@%0d", i, cyc), gnt[i], e_g);
      check($sformatf("rvalid%0d@%0d", i, cyc), rvalid[i], e_rv);
      check($sformatf("busy%0d@%0d", i, cyc), busy[i], occ != 0);
      if (e_rv) begin
        check($sformatf("rdata%0d@%0d", i, cyc), rdata[i], q_rdata[i][q_hd[i] % 16]);
        check($sformatf("err%0d@%0d", i, cyc), err[i], q_err[i][q_hd[i] % 16]);
        q_hd[i]++;
      end else begin
        check($sformatf("idle_rdata%0d@%0d", i, cyc), rdata[i], 32'h0);
        check($sformatf("idle_err%0d@%0d", i, cyc), err[i], 1'b0);
      end
      if (gnt[i]) begin
        if (g_n[i] < LogN) g_cyc[i][g_n[i]] = cyc;
        g_n[i]++;
      end
      if (rvalid[i]) begin
        if (r_n[i] < LogN) begin
          r_cyc[i][r_n[i]] = cyc; r_dat[i][r_n[i]] = rdata[i]; r_er[i][r_n[i]] = err[i];
        end
        r_n[i]++;
      end
      if (e_g) begin
        e_err = (addr[1:0] != 2'b00) || (addr[31:2] >= MemW);
        due = (cyc + lat(i) > last_due[i] + 1) ? cyc + lat(i) : last_due[i] + 1;
        q_rdata[i][q_tl[i] % 16] = e_err ? 32'h0 : mem_m[addr[9:2]];
        q_err[i][q_tl[i] % 16]   = e_err;
        q_due[i][q_tl[i] % 16]   = due;
        q_tl[i]++;
        last_due[i] = due;
      end
    end
    if (we && (waddr < MemW)) mem_m[waddr[7:0]] = wdata;
    lfsr_m = rst ? 16'hACE1 : {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic mem_write(input logic [31:0] a, input logic [31:0] d);
    we = 1'b1; waddr = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  // hold one request until instance 0 grants it; optionally collide a write to word 0
  task automatic fetch_one(input logic [31:0] a, input logic with_wr, input logic [31:0] wv);
    int k;
    req = 1'b1; addr = a; k = 0;
    #1;
    while (!gnt[0] && k < 64) begin
      tick(); #1; k++;
    end
    check("fetch_grant_wait", k < 64, 1'b1);
    if (with_wr) begin
      we = 1'b1; waddr = 32'h0; wdata = wv;
    end
    tick();
    req = 1'b0; we = 1'b0;
  endtask

  int g0_0, g0_1, r0_1, rk, rn_rst0, rn_rst1;
  int gs[N];
  int rs[N];

  initial begin
    rst = 1'b1; req = 1'b1; addr = 32'h0; we = 1'b0; waddr = 32'h0; wdata = 32'h0;
    for (int w = 0; w < MemW; w++) mem_write(w, 32'hA500_0000 | w);
    req = 1'b0;
    rst = 1'b0;
    tick();
    check("reset_busy0", busy[0], 1'b0);
    check("reset_busy1", busy[1], 1'b0);

    mem_write(32'd3, 32'hDEADBEEF);
    fetch_one(32'h0000_000C, 1'b0, 32'h0);
    idle(6);
    check("single_rdata0", r_dat[0][0], 32'hDEADBEEF);
    check("single_err0", r_er[0][0], 1'b0);
    check("single_lat0", r_cyc[0][0] - g_cyc[0][0], 1);
    check("single_rdata1", r_dat[1][0], 32'hDEADBEEF);
    check("single_lat1", r_cyc[1][0] - g_cyc[1][0], 3);

    g0_0 = g_n[0]; g0_1 = g_n[1]; r0_1 = r_n[1];
    req = 1'b1; addr = 32'h0000_0014;
    idle(10);
    req = 1'b0;
    idle(8);
`ifndef IBEX_FETCH_RESP_STALL_EN
    check("held_grants0", g_n[0] - g0_0, 10);
    check("held_grants1", g_n[1] - g0_1, 6);
    check("held_gnt_gap_a", g_cyc[1][g0_1 + 1] - g_cyc[1][g0_1], 1);
    check("held_gnt_gap_b", g_cyc[1][g0_1 + 2] - g_cyc[1][g0_1], 4);
    check("held_first_rv", r_cyc[1][r0_1] - g_cyc[1][g0_1], 3);
    check("held_rv_nogap", r_cyc[1][r0_1 + 1] - r_cyc[1][r0_1], 1);
    check("held_rdata", r_dat[1][r0_1 + 1], 32'hA500_0005);
`endif

    fetch_one(32'h0000_0402, 1'b0, 32'h0);
    fetch_one(32'h0000_1000, 1'b0, 32'h0);
    idle(6);
    check("misalign_err", r_er[0][r_n[0] - 2], 1'b1);
    check("misalign_rdata", r_dat[0][r_n[0] - 2], 32'h0);
    check("range_err", r_er[0][r_n[0] - 1], 1'b1);
    check("range_rdata", r_dat[0][r_n[0] - 1], 32'h0);

    mem_write(32'd0, 32'h0);
    rk = r_n[0];
    fetch_one(32'h0, 1'b1, 32'h1);
    idle(4);
    mem_write(32'd256, 32'h0000_0BAD);
    fetch_one(32'h0, 1'b0, 32'h0);
    idle(4);
    check("collide_old", r_dat[0][rk], 32'h0);
    check("collide_new", r_dat[0][rk + 1], 32'h1);

    req = 1'b1; addr = 32'h0000_0020;
    idle(2);
    req = 1'b0;
`ifndef IBEX_FETCH_RESP_STALL_EN
    check("pre_reset_busy1", busy[1], 1'b1);
`endif
    rn_rst0 = r_n[0]; rn_rst1 = r_n[1];
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle(8);
    check("post_reset_rv0", r_n[0], rn_rst0);
    check("post_reset_rv1", r_n[1], rn_rst1);
    check("post_reset_busy1", busy[1], 1'b0);

    for (int i = 0; i < N; i++) begin gs[i] = g_n[i]; rs[i] = r_n[i]; end
    req = 1'b1; addr = 32'h0000_0040;
    idle(1000);
    req = 1'b0;
    idle(10);
    check("long_resp_count0", r_n[0] - rs[0], g_n[0] - gs[0]);
    check("long_resp_count1", r_n[1] - rs[1], g_n[1] - gs[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ibex_fetch_responder.md
IBEX_FETCH_RESPONDER -- requirements
Module: ibex_fetch_responder

Interface
REQ-001 Parameter MemWords, default 256: number of 32-bit words in the internal instruction store.
REQ-002 Parameter MaxOutstanding, default 2: number of granted requests awaiting rvalid, range 1..4.
REQ-003 Parameter RespLatency, default 1: minimum cycles from grant to rvalid, range 1..4.
REQ-004 clk_i  in  1  the block's only clock; all state updates on its rising edge.
REQ-005 rst_i  in  1  synchronous reset, active-high.
REQ-006 instr_req_i  in  1  fetch request from the initiator.
REQ-007 instr_addr_i  in  32  fetch byte address.
REQ-008 instr_gnt_o  out  1  request accepted this cycle.
REQ-009 instr_rvalid_o  out  1  response valid.
REQ-010 instr_rdata_o  out  32  response data.
REQ-011 instr_err_o  out  1  response error, qualified by instr_rvalid_o.
REQ-012 mem_we_i  in  1  backdoor write enable for loading the store.
REQ-013 mem_waddr_i  in  32  backdoor word index.
REQ-014 mem_wdata_i  in  32  backdoor write data.
REQ-015 busy_o  out  1  high while any granted request is unanswered.

Function
REQ-016 instr_gnt_o is instr_req_i AND registered occupancy < MaxOutstanding AND no stall, with no combinational path from the response side.
REQ-017 On grant, an entry {rdata, err, countdown=RespLatency-1} is pushed in order; the store is read at grant time.
REQ-018 err is set when instr_addr_i[1:0] != 0 or instr_addr_i[31:2] >= MemWords; err entries carry rdata = 0.
REQ-019 Entry countdowns decrement each cycle and saturate at 0.
REQ-020 The head entry with countdown 0 drives instr_rvalid_o high for exactly one cycle and then pops.
REQ-021 At most one rvalid per cycle; responses are strictly in grant order.
REQ-022 A request granted in cycle T gets rvalid no earlier than T+RespLatency, and exactly at T+RespLatency when the queue ahead of it is drained.
REQ-023 Push and pop in the same cycle are legal; occupancy is unchanged.
REQ-024 When full, grant is low even if a pop happens in the same cycle; the request holds and is granted next cycle.
REQ-025 instr_rdata_o and instr_err_o are 0 whenever instr_rvalid_o is low.
REQ-026 Backdoor write and grant to the same word in the same cycle: the grant returns the old data and the write lands.
REQ-027 Backdoor writes with mem_waddr_i >= MemWords are ignored.
REQ-028 busy_o equals (occupancy != 0).

Reset
REQ-029 While rst_i is high: queue empty, instr_gnt_o=0, instr_rvalid_o=0, instr_rdata_o=0, instr_err_o=0, busy_o=0, stall LFSR loaded with its seed.
REQ-030 Reset mid-operation discards all pending responses; no rvalid is issued for them after reset releases.
REQ-031 The store contents are not reset.

Configuration
REQ-032 With IBEX_FETCH_RESP_STALL_EN defined, a 16-bit LFSR (taps 16,14,13,11) advances every cycle, and its bit 0 = 1 forces instr_gnt_o low that cycle.
REQ-033 Without IBEX_FETCH_RESP_STALL_EN, stall is constant 0 and no LFSR is instantiated.

Structure
REQ-034 Package ibex_fetch_resp_pkg holds the resp_entry_t typedef (rdata, err, countdown) and the LFSR seed constant (16'hACE1).
REQ-035 The ordered response queue is one sub-module, ibex_fetch_resp_queue, parameterised by depth.

Verification
REQ-036 Load word 3 with 32'hDEADBEEF; request 32'h0000000C with RespLatency=1 -> gnt in cycle T, rvalid in T+1, rdata 32'hDEADBEEF, err 0.
REQ-037 Hold req continuously, MaxOutstanding=2, RespLatency=3 -> gnt high for 2 cycles, low until the first pop, then in-order rvalids with no gaps.
REQ-038 Request 32'h00000402 and then 32'h00001000 with MemWords=256 -> two rvalids, both with err 1 and rdata 0.
REQ-039 Assert rst_i for one cycle with 2 responses pending -> no rvalid afterwards, busy_o=0.
REQ-040 Backdoor write 32'h1 to word 0 in the same cycle as a grant of address 0 holding 32'h0 -> response 32'h0; the next fetch returns 32'h1.
REQ-041 With IBEX_FETCH_RESP_STALL_EN and req held for 1000 cycles -> grant pattern matches the LFSR reference model and every granted request gets exactly one rvalid.
